// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter
//
// Shares one memory master port between the instruction-fetch and data sides
// of a MIPS core. A three-state FSM (idle, instruction grant, data grant)
// passes the granted requester straight through to memory. Arbitration takes
// one idle cycle. The side that is not granted sees a stall while it requests.
// A stall counter sets a sticky timeout flag when memory has stalled a grant
// for MAX_WAIT cycles. The flag has no effect on arbitration.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break ties toward the
// side not granted last. Without it, ties always go to the data side.
//
// Ports:
//   clk, reset (async, active-low)
//   i_read, i_address           -> i_readdata, i_waitrequest   instruction side
//   d_read, d_write, d_address,
//   d_writedata, d_byteenable   -> d_readdata, d_waitrequest   data side
//   m_address, m_read, m_write, m_writedata, m_byteenable      memory master
//   m_readdata, m_waitrequest                                  memory response
//   timeout                                                    sticky stall flag
module mips_cpu_mem_arbiter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_readdata,
  output logic        i_waitrequest,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_waitrequest,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        timeout
);

  localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            i_req, d_req;
  logic            granted_strobe;
  logic            tie_to_data;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = data side was granted last; resets to instruction side.
  logic last_data_q, last_data_d;

  assign tie_to_data = ~last_data_q;

  always_comb begin
    last_data_d = last_data_q;
    if (state_q == StIdle && state_d != StIdle) begin
      last_data_d = (state_d == StGntD);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  assign tie_to_data = 1'b1;
`endif

  assign granted_strobe = ((state_q == StGntI) && i_req) || ((state_q == StGntD) && d_req);

  // Next state, stall counter and sticky timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (d_req && i_req) begin
          state_d = tie_to_data ? StGntD : StGntI;
        end else if (d_req) begin
          state_d = StGntD;
        end else if (i_req) begin
          state_d = StGntI;
        end
        if (state_d != StIdle) begin
          cnt_d = '0;
        end
      end
      // A dropped strobe aborts. A low waitrequest completes the transfer.
      StGntI: begin
        if (!i_req || !m_waitrequest) begin
          state_d = StIdle;
        end
      end
      StGntD: begin
        if (!d_req || !m_waitrequest) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (granted_strobe && m_waitrequest && cnt_q != MaxCnt) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (cnt_d == MaxCnt && state_q != StIdle) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode from state only. Reset therefore drops the strobes at once.
  always_comb begin
    m_address     = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = '0;
    m_byteenable  = '0;
    i_readdata    = '0;
    d_readdata    = '0;
    i_waitrequest = i_req;
    d_waitrequest = d_req;
    unique case (state_q)
      StGntI: begin
        m_address     = i_address;
        m_read        = i_read;
        m_byteenable  = 4'b1111;
        i_readdata    = m_readdata;
        i_waitrequest = m_waitrequest;
      end
      StGntD: begin
        m_address     = d_address;
        m_write       = d_write;
        m_read        = d_read & ~d_write;
        m_writedata   = d_writedata;
        m_byteenable  = d_byteenable;
        d_readdata    = m_readdata;
        d_waitrequest = m_waitrequest;
      end
      default: ;
    endcase
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
module tb_mips_cpu_mem_arbiter;

  localparam int unsigned MaxWait = 4;

  typedef struct packed {
    logic        i_read;
    logic [31:0] i_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_be;
    logic [31:0] m_rd;
    logic        m_wait;
  } in_t;

  typedef struct packed {
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_be;
    logic [31:0] i_rd;
    logic        i_wait;
    logic [31:0] d_rd;
    logic        d_wait;
    logic        to;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        clk, rst_n;
  logic        i_read, d_read, d_write, m_read, m_write, m_waitrequest;
  logic        i_waitrequest, d_waitrequest, timeout;
  logic [31:0] i_address, i_readdata, d_address, d_writedata, d_readdata;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic [3:0]  d_byteenable, m_byteenable;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the memory port, stalls seen, sticky flag.
  int owner;      // 0 none, 1 instruction, 2 data
  int stalls;
  bit model_to;
  bit last_data;

  mips_cpu_mem_arbiter #(.MAX_WAIT(MaxWait)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_waitrequest(i_waitrequest),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_byteenable (d_byteenable),
    .d_readdata   (d_readdata),
    .d_waitrequest(d_waitrequest),
    .m_address    (m_address),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_byteenable (m_byteenable),
    .m_readdata   (m_readdata),
    .m_waitrequest(m_waitrequest),
    .timeout      (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic in_t vi(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                             logic [31:0] dwd, logic [3:0] dbe, logic [31:0] mrd, logic mw);
    in_t v;
    v = '{i_read: ir, i_address: ia, d_read: dr, d_write: dw, d_address: da,
          d_writedata: dwd, d_be: dbe, m_rd: mrd, m_wait: mw};
    return v;
  endfunction

  function automatic out_t vo(logic [31:0] ma, logic mr, logic mw, logic [31:0] wd,
                              logic [3:0] be, logic [31:0] ird, logic iw, logic [31:0] drd,
                              logic dwt, logic t);
    out_t o;
    o = '{m_address: ma, m_read: mr, m_write: mw, m_writedata: wd, m_be: be, i_rd: ird,
          i_wait: iw, d_rd: drd, d_wait: dwt, to: t};
    return o;
  endfunction

  function automatic out_t got();
    return vo(m_address, m_read, m_write, m_writedata, m_byteenable, i_readdata,
              i_waitrequest, d_readdata, d_waitrequest, timeout);
  endfunction

  task automatic drive(input in_t v);
    i_read        = v.i_read;
    i_address     = v.i_address;
    d_read        = v.d_read;
    d_write       = v.d_write;
    d_address     = v.d_address;
    d_writedata   = v.d_writedata;
    d_byteenable  = v.d_be;
    m_readdata    = v.m_rd;
    m_waitrequest = v.m_wait;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = got();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Drive at the falling edge, sample 2ns later, long before the rising edge.
  task automatic cyc(input in_t v, input string name, input out_t exp);
    @(negedge clk);
    drive(v);
    #2;
    check(name, exp);
  endtask

  function automatic out_t model_out(in_t v);
    out_t o;
    o = vo(0, 0, 0, 0, 0, 0, v.i_read, 0, v.d_read | v.d_write, model_to);
    if (owner == 1) begin
      o.m_address = v.i_address;
      o.m_read    = v.i_read;
      o.m_be      = 4'hF;
      o.i_rd      = v.m_rd;
      o.i_wait    = v.m_wait;
    end else if (owner == 2) begin
      o.m_address   = v.d_address;
      o.m_write     = v.d_write;
      o.m_read      = v.d_read & ~v.d_write;
      o.m_writedata = v.d_writedata;
      o.m_be        = v.d_be;
      o.d_rd        = v.m_rd;
      o.d_wait      = v.m_wait;
    end
    return o;
  endfunction

  task automatic model_edge(input in_t v);
    bit ireq, dreq, strobe;
    ireq = v.i_read;
    dreq = v.d_read | v.d_write;
    if (owner == 0) begin
      if (ireq && dreq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        owner = last_data ? 1 : 2;
`else
        owner = 2;
`endif
      end else if (dreq) begin
        owner = 2;
      end else if (ireq) begin
        owner = 1;
      end
      if (owner != 0) begin
        stalls    = 0;
        last_data = (owner == 2);
      end
    end else begin
      strobe = (owner == 1) ? ireq : dreq;
      if (strobe && v.m_wait) begin
        if (stalls < int'(MaxWait)) stalls++;
        if (stalls == int'(MaxWait)) model_to = 1'b1;
      end else begin
        owner = 0;
      end
    end
  endtask

  task automatic model_reset();
    owner     = 0;
    stalls    = 0;
    model_to  = 1'b0;
    last_data = 1'b0;
  endtask

  vec_t tbl[18];
  localparam logic [31:0] IA = 32'h0000_0400;
  localparam logic [31:0] DA = 32'h0000_2000;
  localparam logic [31:0] RD = 32'hA5A5_A5A5;
  localparam logic [31:0] BA = 32'hBFC0_0000;
  localparam logic [31:0] LI = 32'h2402_0005;
  localparam logic [31:0] WA = 32'h0000_1000;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  initial begin
    in_t  v, w;
    out_t e;

    // Tie from reset: data first, then instruction.
    tbl[0]  = '{vi(1, IA, 1, 0, DA, 0, 4'hF, RD, 0), vo(0, 0, 0, 0, 0, 0, 1, 0, 1, 0)};
    tbl[1]  = '{vi(1, IA, 1, 0, DA, 0, 4'hF, RD, 0), vo(DA, 1, 0, 0, 4'hF, 0, 1, RD, 0, 0)};
    tbl[2]  = '{vi(1, IA, 0, 0, DA, 0, 4'hF, RD, 0), vo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[3]  = '{vi(1, IA, 0, 0, DA, 0, 4'hF, RD, 0), vo(IA, 1, 0, 0, 4'hF, RD, 0, 0, 0, 0)};
    tbl[4]  = '{vi(0, 0, 0, 0, 0, 0, 0, RD, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // Boot fetch with no stall.
    tbl[5]  = '{vi(1, BA, 0, 0, 0, 0, 0, LI, 0), vo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[6]  = '{vi(1, BA, 0, 0, 0, 0, 0, LI, 0), vo(BA, 1, 0, 0, 4'hF, LI, 0, 0, 0, 0)};
    tbl[7]  = '{vi(0, BA, 0, 0, 0, 0, 0, LI, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // Half-word write with three stall cycles.
    tbl[8]  = '{vi(0, 0, 0, 1, WA, WD, 4'h3, 0, 1), vo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    tbl[9]  = '{vi(0, 0, 0, 1, WA, WD, 4'h3, 0, 1), vo(WA, 0, 1, WD, 4'h3, 0, 0, 0, 1, 0)};
    tbl[10] = '{vi(0, 0, 0, 1, WA, WD, 4'h3, 0, 1), vo(WA, 0, 1, WD, 4'h3, 0, 0, 0, 1, 0)};
    tbl[11] = '{vi(0, 0, 0, 1, WA, WD, 4'h3, 0, 1), vo(WA, 0, 1, WD, 4'h3, 0, 0, 0, 1, 0)};
    tbl[12] = '{vi(0, 0, 0, 1, WA, WD, 4'h3, 0, 0), vo(WA, 0, 1, WD, 4'h3, 0, 0, 0, 0, 0)};
    tbl[13] = '{vi(0, 0, 0, 0, WA, WD, 4'h3, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // Instruction side drops its strobe mid-stall: abort.
    tbl[14] = '{vi(1, IA, 0, 0, 0, 0, 0, RD, 1), vo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[15] = '{vi(1, IA, 0, 0, 0, 0, 0, RD, 1), vo(IA, 1, 0, 0, 4'hF, RD, 1, 0, 0, 0)};
    tbl[16] = '{vi(0, IA, 0, 0, 0, 0, 0, RD, 1), vo(IA, 0, 0, 0, 4'hF, RD, 1, 0, 0, 0)};
    tbl[17] = '{vi(0, IA, 0, 0, 0, 0, 0, RD, 1), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    rst_n = 1'b0;
    drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check("reset_state", vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].in, $sformatf("vec%0d", i), tbl[i].exp);
    end

    // Timeout: four stalled grant cycles set the flag, which then sticks.
    v = vi(0, 0, 1, 0, DA, 0, 4'hF, RD, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 5) v.m_wait = 1'b0;
      if (k >= 6) v = vi(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(v);
      #2;
      check_bit($sformatf("timeout_k%0d", k), timeout, k >= 5);
    end

    // Asynchronous reset in the middle of a data write grant.
    w = vi(0, 0, 0, 1, WA, WD, 4'hF, 0, 1);
    cyc(w, "rst_pre_idle", vo(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    cyc(w, "rst_pre_gnt", vo(WA, 0, 1, WD, 4'hF, 0, 0, 0, 1, 1));
    #1 rst_n = 1'b0;
    #1 check("rst_async", vo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_release_idle", vo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    #2 check("rst_regrant", vo(WA, 0, 1, WD, 4'hF, 0, 0, 0, 1, 0));
    drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Random traffic against the model, with an occasional async reset pulse.
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n % 400 == 399) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
      end
      v.i_read      = ($urandom_range(0, 2) != 0);
      v.i_address   = $urandom;
      v.d_read      = ($urandom_range(0, 2) == 0);
      v.d_write     = ($urandom_range(0, 2) == 0);
      v.d_address   = $urandom;
      v.d_writedata = $urandom;
      v.d_be        = 4'($urandom);
      v.m_rd        = $urandom;
      v.m_wait      = ($urandom_range(0, 2) != 0);
      drive(v);
      #1;
      e = model_out(v);
      check($sformatf("rand%0d", n), e);
      model_edge(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
